// File: rtl/life_pkg.sv
// life_pkg: shared state encoding, sizing constants and the Game-of-Life cell rule.
package life_pkg;
    typedef enum logic [3:0] {IDLE, PRIME0, PRIME1, PRIME2, PRIME3, EVAL, SHIFT, GEN_END, DONE} state_t;
    localparam int CNT_W = 4;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    // Count is four bits wide so a fully surrounded cell sees 8, not 0.
    function automatic logic cell_next(input logic [7:0] nbrs, input logic alive);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + CNT_W'(nbrs[i]);
        return (cnt == CNT_W'(3)) | (alive & (cnt == CNT_W'(2)));
    endfunction
endpackage

// File: rtl/life_row_rule.sv
// life_row_rule: combinational next-state of one row from a 3-row window, columns wrap toroidally.
module life_row_rule
    import life_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic [COLS-1:0] i_top,
    input  logic [COLS-1:0] i_mid,
    input  logic [COLS-1:0] i_bot,
    output logic [COLS-1:0] o_next
);
    genvar c;
    for (c = 0; c < COLS; c++) begin : g_col
        localparam int L = (c + COLS - 1) % COLS;
        localparam int R = (c + 1) % COLS;
        assign o_next[c] = cell_next({i_top[L], i_top[c], i_top[R], i_mid[L], i_mid[R],
                                      i_bot[L], i_bot[c], i_bot[R]}, i_mid[c]);
    end
endmodule

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: ping-pong generation sequencer streaming rows through a 3-row window.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ROW_AW = 3,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GEN_W-1:0]  num_gens,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              cur_bank,
    output logic [GEN_W-1:0]  gen_count,
    output logic              rd_en,
    output logic [ROW_AW:0]   rd_addr,
    input  logic [COLS-1:0]   rd_data,
    output logic              wr_en,
    output logic [ROW_AW:0]   wr_addr,
    output logic [COLS-1:0]   wr_data
);
    state_t              r_state;
    logic [ROW_AW-1:0]   r_row;
    logic [GEN_W-1:0]    r_remaining;
    logic [GEN_W-1:0]    r_gen;
    logic [COLS-1:0]     r_top, r_mid, r_bot;
    logic                r_busy, r_done, r_bank;
    logic [COLS-1:0]     w_next;
    logic [ROW_AW-1:0]   w_ahead, w_rd_row;
    logic                w_cap, w_last;

    life_row_rule #(.COLS(COLS)) u_rule (
        .i_top (r_top),
        .i_mid (r_mid),
        .i_bot (r_bot),
        .o_next(w_next)
    );

    // Memory strobes decode straight from the registered state so the write
    // row pairs with the window captured on the previous edge.
    always_comb begin
        w_last   = r_row == ROW_AW'(ROWS - 1);
        w_ahead  = r_row >= ROW_AW'(ROWS - 2) ? r_row - ROW_AW'(ROWS - 2) : r_row + ROW_AW'(2);
        w_rd_row = r_state == PRIME0 ? ROW_AW'(ROWS - 1) :
                   r_state == PRIME1 ? '0 :
                   r_state == PRIME2 ? ROW_AW'(1) : w_ahead;
        w_cap    = r_state == PRIME1 || r_state == PRIME2 || r_state == PRIME3 || r_state == SHIFT;
        rd_en    = r_state == PRIME0 || r_state == PRIME1 || r_state == PRIME2 || (r_state == EVAL && !w_last);
        rd_addr  = {r_bank, w_rd_row};
        wr_en    = r_state == EVAL;
        wr_addr  = {~r_bank, r_row};
        wr_data  = w_next;
        busy      = r_busy;
        done      = r_done;
        cur_bank  = r_bank;
        gen_count = r_gen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_remaining <= '0;
            r_gen       <= '0;
            r_top       <= '0;
            r_mid       <= '0;
            r_bot       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bank      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cap) {r_top, r_mid, r_bot} <= {r_mid, r_bot, rd_data};
            case (r_state)
                IDLE: if (start) begin
                    r_busy      <= 1'b1;
                    r_remaining <= num_gens;
                    r_gen       <= '0;
                    r_state     <= num_gens == '0 ? DONE : PRIME0;
                end
                PRIME0: r_state <= PRIME1;
                PRIME1: r_state <= PRIME2;
                PRIME2: r_state <= PRIME3;
                PRIME3: begin
                    r_row   <= '0;
                    r_state <= EVAL;
                end
                EVAL: r_state <= w_last ? GEN_END : SHIFT;
                SHIFT: begin
                    r_row   <= r_row + ROW_AW'(1);
                    r_state <= EVAL;
                end
                GEN_END: begin
                    r_bank      <= ~r_bank;
                    r_gen       <= r_gen + GEN_W'(1);
                    r_remaining <= r_remaining - GEN_W'(1);
                    r_state     <= (r_remaining == GEN_W'(1) || stop) ? DONE : PRIME0;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: directed Game-of-Life runs against a bench-owned row RAM, checked by a scoreboard monitor.
module tb_life_gen_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] num_gens;
    logic        busy, done, cur_bank;
    logic [15:0] gen_count;
    logic        rd_en, wr_en;
    logic [3:0]  rd_addr, wr_addr;
    logic [7:0]  rd_data, wr_data;

    life_gen_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_gens(num_gens), .stop(stop),
        .busy(busy), .done(done), .cur_bank(cur_bank), .gen_count(gen_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
    localparam logic [63:0] BLOCK   = 64'h8100_0000_0000_0081;
    localparam logic [63:0] SQUARE  = 64'h0000_001C_1C1C_0000;
    localparam logic [63:0] RING    = 64'h0000_0814_2214_0800;

    logic [7:0]  mem [16];
    int          cyc = 0, nwr_cnt = 0, nrd_cnt = 0;
    logic        ld_en = 1'b0, ld_bank = 1'b0;
    logic [63:0] ld_grid = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            nrd_cnt <= nrd_cnt + 1;
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            nwr_cnt <= nwr_cnt + 1;
        end
        if (ld_en) for (int r = 0; r < 8; r++) mem[{ld_bank, 3'(r)}] <= ld_grid[8*r +: 8];
    end

    // kind 0: end-of-run result on done; 1: immediate snapshot of idle outputs; 2: expired wait
    typedef struct {
        string       name;
        int          kind;
        int          lat;
        logic        bank;
        logic [15:0] gc;
        bit          chk_gc;
        int          nwr;
        int          nrd;
        logic [63:0] grid;
        int          t0;
        int          wr0;
        int          rd0;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic [63:0] grid_of(input logic b);
        logic [63:0] g;
        for (int r = 0; r < 8; r++) g[8*r +: 8] = mem[{b, 3'(r)}];
        return g;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].kind == 2) begin
            e = sb.pop_front();
            check({e.name, " timeout"}, 64'd1, 64'd0);
        end else if (sb.size() != 0 && sb[0].kind == 1) begin
            e = sb.pop_front();
            check({e.name, " ctrl"}, {busy, done, rd_en, wr_en}, 4'b0);
            check({e.name, " cur_bank"}, cur_bank, e.bank);
            check({e.name, " gen_count"}, gen_count, e.gc);
            check({e.name, " writes"}, nwr_cnt - e.wr0, e.nwr);
        end else if (done) begin
            if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check({e.name, " latency"}, cyc - e.t0, e.lat);
                check({e.name, " busy"}, busy, 1'b0);
                check({e.name, " cur_bank"}, cur_bank, e.bank);
                if (e.chk_gc) check({e.name, " gen_count"}, gen_count, e.gc);
                check({e.name, " writes"}, nwr_cnt - e.wr0, e.nwr);
                check({e.name, " reads"}, nrd_cnt - e.rd0, e.nrd);
                check({e.name, " grid"}, grid_of(e.bank), e.grid);
            end
        end
    end

    logic bank_m = 1'b0;

    task automatic wait_sb(input int lim);
        exp_t t;
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            t.name = sb[0].name;
            t.kind = 2;
            sb.delete();
            sb.push_back(t);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic snap(input string nm, input logic b, input int wr0);
        exp_t e;
        e.name = nm; e.kind = 1; e.bank = b; e.gc = '0; e.nwr = 0; e.wr0 = wr0;
        sb.push_back(e);
        wait_sb(10);
    endtask

    task automatic run(input string nm, input bit ld, input logic [63:0] pat, input int ng,
                       input int gens, input logic [63:0] exp_grid, input bit chk_gc, input int stop_at);
        exp_t e;
        if (ld) begin
            ld_grid = pat; ld_bank = bank_m; ld_en = 1'b1;
            @(negedge clk);
            ld_en = 1'b0;
        end
        e.name = nm; e.kind = 0; e.lat = 2 + 20 * gens; e.bank = bank_m ^ gens[0];
        e.gc = 16'(gens); e.chk_gc = chk_gc; e.nwr = 8 * gens; e.nrd = 10 * gens;
        e.grid = exp_grid; e.t0 = cyc; e.wr0 = nwr_cnt; e.rd0 = nrd_cnt;
        sb.push_back(e);
        start = 1'b1; num_gens = 16'(ng);
        @(negedge clk);
        start = 1'b0;
        if (stop_at > 0) begin
            repeat (stop_at - 1) @(negedge clk);
            stop = 1'b1; start = 1'b1; num_gens = 16'd1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_sb(2000);
        stop = 1'b0;
        bank_m = e.bank;
    endtask

    initial begin
        int k;
        exp_t t;
        rst = 1'b1; start = 1'b0; stop = 1'b0; num_gens = '0;
        repeat (3) @(negedge clk);
        snap("reset", 1'b0, nwr_cnt);
        rst = 1'b0;
        @(negedge clk);
        run("blinker_1",    1'b1, BLINK_H, 1,  1,  BLINK_V, 1'b1, 0);
        run("blinker_back", 1'b0, '0,      1,  1,  BLINK_H, 1'b1, 0);
        run("blinker_2",    1'b1, BLINK_H, 2,  2,  BLINK_H, 1'b1, 0);
        run("glider_32",    1'b1, GLIDER,  32, 32, GLIDER,  1'b1, 0);
        run("corner_block", 1'b1, BLOCK,   5,  5,  BLOCK,   1'b1, 0);
        run("square_8nbr",  1'b1, SQUARE,  1,  1,  RING,    1'b1, 0);
        run("stop_gen3",    1'b1, BLINK_H, 10, 3,  BLINK_V, 1'b1, 45);
        run("zero_gens",    1'b0, '0,      0,  0,  BLINK_V, 1'b0, 0);
        start = 1'b1; num_gens = 16'd10;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!wr_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!wr_en) begin
            t.name = "rst_mid_eval"; t.kind = 2;
            sb.push_back(t);
            wait_sb(10);
        end else begin
            rst = 1'b1;
            #1;
            k = nwr_cnt;
            snap("rst_mid_eval", 1'b0, k);
            rst = 1'b0;
            repeat (40) @(negedge clk);
            snap("after_rst", 1'b0, k);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
